uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- 8N1 UART receiver using 16x oversampling.
- Sits directly downstream of the baud tick generator and consumes its single-cycle s_tick strobe as the sample enable.
- Recovers each serial frame into a parallel byte and holds it in a one-entry output register with a valid/read handshake.
- Reports framing and overrun errors to the processor-side consumer.

Parameters:
- DATA_BITS, 8, number of data bits per frame, sent LSB first.
- OS_TICKS, 16, s_tick pulses per bit period; must be even and at least 4.
- SB_TICKS, 16, s_tick pulses spent in the stop bit; 16 means 1 stop bit.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  synchronous active-low reset.
- s_tick  in  1  oversample strobe from the baud tick generator; 1 clk cycle wide.
- rx  in  1  asynchronous serial line; idles high.
- rd_en  in  1  consumer acknowledges dout; single-cycle pulse.
- dout  out  DATA_BITS  last accepted byte.
- dout_valid  out  1  dout holds an unread byte.
- rx_done_tick  out  1  1-cycle pulse when a byte is loaded into dout.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overrun_err  out  1  sticky: a byte was dropped because dout was still unread.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset, evaluated on the rising clk edge while rst_n=0:
  - state=IDLE; s_cnt=0; n_cnt=0; shift register=0.
  - Both synchronizer flops=1; dout=0.
  - dout_valid, rx_done_tick, frame_err, overrun_err and busy all =0.
  - Reset mid-frame abandons the frame with no partial load.
- Synchronizer: rx passes through 2 flops to give rx_s. All decisions use rx_s, so line-to-decision latency is 2 clk cycles.
- Everything below advances only in cycles where s_tick=1, except the IDLE start detect and the rd_en handling.
- IDLE:
  - rx_s=0 in any cycle (tick not required) -> START, with s_cnt=0.
- START, on each tick:
  - If s_cnt==OS_TICKS/2-1: rx_s=0 -> DATA with s_cnt=0, n_cnt=0; rx_s=1 -> IDLE (glitch rejected, no flags).
  - Otherwise s_cnt++.
- DATA, on each tick:
  - If s_cnt==OS_TICKS-1: s_cnt=0; shift = {rx_s, shift[DATA_BITS-1:1]}. If n_cnt==DATA_BITS-1 -> STOP, else n_cnt++.
  - Otherwise s_cnt++.
  - Net effect: each bit is sampled at its midpoint.
- STOP, on each tick:
  - If s_cnt==SB_TICKS-1 -> IDLE. The completion action is taken in this cycle:
    - rx_s=1: byte complete (load rules below).
    - rx_s=0: frame_err<=1; byte discarded; dout and dout_valid unchanged.
  - Otherwise s_cnt++.
- Load rules on byte complete:
  - dout_valid=0, or rd_en=1 in the same cycle: dout<=shift, dout_valid<=1, rx_done_tick=1 for that cycle only.
  - dout_valid=1 and rd_en=0: byte discarded; overrun_err<=1; dout unchanged; no rx_done_tick.
- rd_en handling:
  - rd_en=1 clears dout_valid, frame_err and overrun_err on the next edge.
  - If an error event occurs in the same cycle as rd_en, the set wins and the flag reads 1.
  - rd_en while dout_valid=0 clears the flags only.
- Counter widths: s_cnt is wide enough for max(OS_TICKS, SB_TICKS)-1; n_cnt for DATA_BITS-1. Neither counter ever wraps beyond its terminal value.
- Back-to-back frames: a new start bit is accepted on the first cycle rx_s=0 after returning to IDLE. There is no idle gap requirement.
- A start edge arriving mid-STOP is ignored until STOP completes.

Test Plan:
- Reset then send 0xA5 (8N1, s_tick every 4 clk, 16 ticks/bit):
  - dout=0xA5 with dout_valid=1.
  - rx_done_tick high exactly 1 cycle, about 10 bit periods after the start edge.
  - frame_err=0, overrun_err=0, busy low afterwards.
- Glitch: rx low for 4 ticks then high:
  - Returns to IDLE after the mid-start sample; no rx_done_tick, no flags.
  - A following 0x3C frame is received correctly.
- Framing error: send 0x55 with the stop bit held low:
  - frame_err=1; dout_valid stays 0.
  - rd_en clears frame_err to 0.
- Overrun: send 0x11 and 0x22 with no rd_en:
  - dout=0x11; overrun_err=1; only one rx_done_tick.
  - rd_en -> dout_valid=0, overrun_err=0.
- Simultaneous rd_en with completion of a second byte 0x7E:
  - dout=0x7E; dout_valid stays 1; overrun_err=0; rx_done_tick=1.
- Assert rst_n=0 for 1 cycle during bit 3 of 0xF0:
  - All outputs return to 0 and busy=0.
  - The remainder of the frame produces no spurious byte.
  - The next 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver with 16x oversampling, one-entry output register,
// valid/read handshake and sticky framing/overrun error flags.
module uart_rx_os #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned OS_TICKS  = 16,
    parameter int unsigned SB_TICKS  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_tick,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    output logic                 rx_done_tick,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int unsigned S_MAX = (OS_TICKS > SB_TICKS) ? OS_TICKS : SB_TICKS;
    localparam int unsigned S_W   = (S_MAX > 2) ? $clog2(S_MAX) : 1;
    localparam int unsigned N_W   = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

    localparam logic [S_W-1:0] S_HALF = S_W'(OS_TICKS / 2 - 1);
    localparam logic [S_W-1:0] S_BIT  = S_W'(OS_TICKS - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICKS - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    logic [S_W-1:0]       s_cnt;
    logic [N_W-1:0]       n_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 rx_meta;
    logic                 rx_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            s_cnt        <= '0;
            n_cnt        <= '0;
            shift        <= '0;
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            dout         <= '0;
            dout_valid   <= 1'b0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            overrun_err  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rx_meta      <= rx;
            rx_s         <= rx_meta;
            rx_done_tick <= 1'b0;

            // Read acknowledge clears first so that error sets below take priority
            if (rd_en) begin
                dout_valid  <= 1'b0;
                frame_err   <= 1'b0;
                overrun_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s_cnt <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_cnt == S_HALF) begin
                            s_cnt <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                                n_cnt <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            s_cnt <= s_cnt + S_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_cnt == S_BIT) begin
                            s_cnt <= '0;
                            shift <= {rx_s, shift[DATA_BITS-1:1]};
                            if (n_cnt == N_LAST) begin
                                state <= STOP;
                            end else begin
                                n_cnt <= n_cnt + N_W'(1);
                            end
                        end else begin
                            s_cnt <= s_cnt + S_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s_cnt == S_STOP) begin
                            state <= IDLE;
                            s_cnt <= '0;
                            busy  <= 1'b0;
                            if (rx_s) begin
                                if (!dout_valid || rd_en) begin
                                    dout         <= shift;
                                    dout_valid   <= 1'b1;
                                    rx_done_tick <= 1'b1;
                                end else begin
                                    overrun_err  <= 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            s_cnt <= s_cnt + S_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: serial frames driven at 64 clk per bit,
// received bytes checked against a queue of expected values.
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       rx_done_tick;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int drop_cyc = 0;
    int last_done_cyc = 0;
    logic [1:0] tdiv = 2'd0;
    logic [7:0] exp_q[$];

    uart_rx_os dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_tick       (s_tick),
        .rx           (rx),
        .rd_en        (rd_en),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .overrun_err  (overrun_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // One s_tick every 4 clocks
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        tdiv   <= tdiv + 2'd1;
        s_tick <= (tdiv == 2'd3);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every load must match the oldest expected byte
    always @(negedge clk) begin
        if (rx_done_tick) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("done_unexpected", 32'(rx_done_tick), 32'd0);
            end else begin
                check("sb_dout", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int stop_low);
        @(negedge clk);
        rx = 1'b0;
        drop_cyc = cyc;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (64) @(negedge clk);
        end
        if (stop_low > 0) begin
            rx = 1'b0;
            repeat (stop_low) @(negedge clk);
        end
        rx = 1'b1;
        repeat (64 - stop_low) @(negedge clk);
    endtask

    task automatic pulse_rd;
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"},    32'(dout),        32'd0);
        check({tag, "_valid"},   32'(dout_valid),  32'd0);
        check({tag, "_done"},    32'(rx_done_tick), 32'd0);
        check({tag, "_ferr"},    32'(frame_err),   32'd0);
        check({tag, "_oerr"},    32'(overrun_err), 32'd0);
        check({tag, "_busy"},    32'(busy),        32'd0);
    endtask

    initial begin
        int d0;
        int lat;

        repeat (4) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(20);

        // Basic frame
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 0);
        idle(64);
        check("a5_dout",  32'(dout),        32'hA5);
        check("a5_valid", 32'(dout_valid),  32'd1);
        check("a5_ferr",  32'(frame_err),   32'd0);
        check("a5_oerr",  32'(overrun_err), 32'd0);
        check("a5_busy",  32'(busy),        32'd0);
        check("a5_ndone", 32'(done_cnt),    32'd1);
        lat = last_done_cyc - drop_cyc;
        check("a5_latency_window", 32'((lat >= 600) && (lat <= 624)), 32'd1);
        pulse_rd();
        check("a5_rd_valid", 32'(dout_valid), 32'd0);

        // Glitch on the start bit
        d0 = done_cnt;
        @(negedge clk);
        rx = 1'b0;
        idle(16);
        rx = 1'b1;
        idle(100);
        check("glitch_busy",  32'(busy),            32'd0);
        check("glitch_ndone", 32'(done_cnt - d0),   32'd0);
        check("glitch_ferr",  32'(frame_err),       32'd0);
        check("glitch_oerr",  32'(overrun_err),     32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 0);
        idle(64);
        check("3c_dout",  32'(dout),       32'h3C);
        check("3c_valid", 32'(dout_valid), 32'd1);
        pulse_rd();

        // Framing error: stop bit low through its sample point
        send_frame(8'h55, 56);
        idle(100);
        check("ferr_set",   32'(frame_err),  32'd1);
        check("ferr_valid", 32'(dout_valid), 32'd0);
        check("ferr_busy",  32'(busy),       32'd0);
        pulse_rd();
        check("ferr_clear", 32'(frame_err),  32'd0);

        // Overrun: second byte dropped while first is unread
        d0 = done_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 0);
        idle(32);
        send_frame(8'h22, 0);
        idle(64);
        check("ovr_dout",  32'(dout),          32'h11);
        check("ovr_set",   32'(overrun_err),   32'd1);
        check("ovr_valid", 32'(dout_valid),    32'd1);
        check("ovr_ndone", 32'(done_cnt - d0), 32'd1);
        pulse_rd();
        check("ovr_rd_valid", 32'(dout_valid),  32'd0);
        check("ovr_rd_clear", 32'(overrun_err), 32'd0);

        // Read acknowledge lands on the completion edge of 0x7E
        exp_q.push_back(8'h42);
        send_frame(8'h42, 0);
        idle(32);
        check("42_valid", 32'(dout_valid), 32'd1);
        d0 = done_cnt;
        exp_q.push_back(8'h7E);
        fork
            send_frame(8'h7E, 0);
            begin
                bit seen = 1'b0;
                bit fired = 1'b0;
                int nt = 0;
                for (int k = 0; k < 200 && !seen; k++) begin
                    @(posedge clk);
                    if (rx == 1'b0) seen = 1'b1;
                end
                repeat (2) @(posedge clk);
                // 8 start + 8*16 data + 16 stop ticks to the completion edge
                for (int k = 0; k < 2000 && !fired; k++) begin
                    @(negedge clk);
                    if (s_tick) begin
                        nt++;
                        if (nt == 152) begin
                            rd_en = 1'b1;
                            @(negedge clk);
                            rd_en = 1'b0;
                            fired = 1'b1;
                        end
                    end
                end
                check("sim_rd_fired", 32'(fired), 32'd1);
            end
        join
        idle(16);
        check("sim_dout",  32'(dout),          32'h7E);
        check("sim_valid", 32'(dout_valid),    32'd1);
        check("sim_oerr",  32'(overrun_err),   32'd0);
        check("sim_ndone", 32'(done_cnt - d0), 32'd1);

        // One-cycle reset late in bit 3 of 0xF0
        d0 = done_cnt;
        fork
            send_frame(8'hF0, 0);
            begin
                @(negedge clk);
                idle(300);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check_all_zero("midrst");
            end
        join
        idle(200);
        check("midrst_ndone", 32'(done_cnt - d0), 32'd0);
        check("midrst_busy",  32'(busy),          32'd0);
        check("midrst_valid", 32'(dout_valid),    32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 0);
        idle(64);
        check("81_dout",  32'(dout),       32'h81);
        check("81_valid", 32'(dout_valid), 32'd1);
        check("81_ferr",  32'(frame_err),  32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
